// File: rtl/pkt_reader_if.sv
// Purpose : bundles the descriptor-FIFO, packet-RAM read and tx byte-stream signals of pkt_reader.
// Latency : n/a (wiring only).
// Backpressure: tx_ready from the sink stalls the reader; the FIFO side is pop-strobe, the RAM side has a fixed 1-cycle read.
// Ports   : master = reader side (drives fifo_read_en, ram_rd_*, tx_*, busy, pkt_done);
//           slave  = environment side (drives fifo_*, ram_rd_data, tx_ready).
interface pkt_reader_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
);
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_last_addr;
    logic [LEN_W-1:0]  fifo_data_size;
    logic              fifo_read_en;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [7:0]        ram_rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_sof;
    logic              tx_eof;
    logic              busy;
    logic              pkt_done;

    modport master (
        input  fifo_empty, fifo_last_addr, fifo_data_size, ram_rd_data, tx_ready,
        output fifo_read_en, ram_rd_en, ram_rd_addr, tx_data, tx_valid, tx_sof, tx_eof,
               busy, pkt_done
    );

    modport slave (
        output fifo_empty, fifo_last_addr, fifo_data_size, ram_rd_data, tx_ready,
        input  fifo_read_en, ram_rd_en, ram_rd_addr, tx_data, tx_valid, tx_sof, tx_eof,
               busy, pkt_done
    );
endinterface

// File: rtl/pkt_reader.sv
// Purpose : pops one (last_addr, size) descriptor, reads the packet bytes from the circular RAM and streams them with sof/eof.
// Latency : descriptor seen in IDLE -> pop strobe +1, RAM read +2, first byte valid +4; 3 cycles per byte minimum.
// Backpressure: tx_ready low holds the presented byte stable in SEND; no re-read, no further RAM access until accepted.
// Ports   : clk, rst_n (async active-low), bus (pkt_reader_if.master): descriptor FIFO head/pop, RAM read port,
//           tx byte stream (data/valid/ready/sof/eof), busy and pkt_done status. All outputs are registered.
module pkt_reader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    pkt_reader_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_FETCH,
        ST_WAIT,
        ST_SEND
    } state_t;

    state_t            r_state,        w_state_nxt;
    logic [ADDR_W-1:0] r_last_addr,    w_last_addr_nxt;
    logic [LEN_W-1:0]  r_size,         w_size_nxt;
    logic [ADDR_W-1:0] r_rd_addr,      w_rd_addr_nxt;
    logic [LEN_W-1:0]  r_remaining,    w_remaining_nxt;
    logic              r_first,        w_first_nxt;
    logic              r_fifo_read_en, w_fifo_read_en_nxt;
    logic              r_ram_rd_en,    w_ram_rd_en_nxt;
    logic [7:0]        r_tx_data,      w_tx_data_nxt;
    logic              r_tx_valid,     w_tx_valid_nxt;
    logic              r_tx_sof,       w_tx_sof_nxt;
    logic              r_tx_eof,       w_tx_eof_nxt;
    logic              r_busy,         w_busy_nxt;
    logic              r_pkt_done,     w_pkt_done_nxt;

    logic              w_last_byte;

    assign w_last_byte = (r_remaining == LEN_W'(1));

    // Next-state and next-output logic. Outputs are registered, so a strobe
    // that must be high *during* a state is raised on the transition into it.
    always_comb begin
        w_state_nxt        = r_state;
        w_last_addr_nxt    = r_last_addr;
        w_size_nxt         = r_size;
        w_rd_addr_nxt      = r_rd_addr;
        w_remaining_nxt    = r_remaining;
        w_first_nxt        = r_first;
        w_fifo_read_en_nxt = 1'b0;
        w_ram_rd_en_nxt    = 1'b0;
        w_tx_data_nxt      = r_tx_data;
        w_tx_valid_nxt     = r_tx_valid;
        w_tx_sof_nxt       = r_tx_sof;
        w_tx_eof_nxt       = r_tx_eof;
        w_pkt_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!bus.fifo_empty) begin
                    w_last_addr_nxt    = bus.fifo_last_addr;
                    w_size_nxt         = bus.fifo_data_size;
                    w_fifo_read_en_nxt = 1'b1;
                    w_state_nxt        = ST_POP;
                end
            end
            ST_POP: begin
                if (r_size == '0) begin
                    // Empty descriptor: consumed but produces nothing.
                    w_state_nxt = ST_IDLE;
                end else begin
                    // Packet occupies [last-size+1 .. last] in the circular RAM.
                    w_rd_addr_nxt   = r_last_addr - ADDR_W'(r_size) + ADDR_W'(1);
                    w_remaining_nxt = r_size;
                    w_first_nxt     = 1'b1;
                    w_ram_rd_en_nxt = 1'b1;
                    w_state_nxt     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Read issued during this state; data arrives in WAIT.
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_tx_data_nxt  = bus.ram_rd_data;
                w_tx_valid_nxt = 1'b1;
                w_tx_sof_nxt   = r_first;
                w_tx_eof_nxt   = w_last_byte;
                w_state_nxt    = ST_SEND;
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    w_tx_valid_nxt  = 1'b0;
                    w_tx_sof_nxt    = 1'b0;
                    w_tx_eof_nxt    = 1'b0;
                    w_first_nxt     = 1'b0;
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                    w_rd_addr_nxt   = r_rd_addr + ADDR_W'(1);
                    if (w_last_byte) begin
                        w_pkt_done_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_ram_rd_en_nxt = 1'b1;
                        w_state_nxt     = ST_FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_last_addr    <= '0;
            r_size         <= '0;
            r_rd_addr      <= '0;
            r_remaining    <= '0;
            r_first        <= 1'b0;
            r_fifo_read_en <= 1'b0;
            r_ram_rd_en    <= 1'b0;
            r_tx_data      <= '0;
            r_tx_valid     <= 1'b0;
            r_tx_sof       <= 1'b0;
            r_tx_eof       <= 1'b0;
            r_busy         <= 1'b0;
            r_pkt_done     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_last_addr    <= w_last_addr_nxt;
            r_size         <= w_size_nxt;
            r_rd_addr      <= w_rd_addr_nxt;
            r_remaining    <= w_remaining_nxt;
            r_first        <= w_first_nxt;
            r_fifo_read_en <= w_fifo_read_en_nxt;
            r_ram_rd_en    <= w_ram_rd_en_nxt;
            r_tx_data      <= w_tx_data_nxt;
            r_tx_valid     <= w_tx_valid_nxt;
            r_tx_sof       <= w_tx_sof_nxt;
            r_tx_eof       <= w_tx_eof_nxt;
            r_busy         <= w_busy_nxt;
            r_pkt_done     <= w_pkt_done_nxt;
        end
    end

    // The read address register already holds the current byte's address while in FETCH.
    assign bus.fifo_read_en = r_fifo_read_en;
    assign bus.ram_rd_en    = r_ram_rd_en;
    assign bus.ram_rd_addr  = r_rd_addr;
    assign bus.tx_data      = r_tx_data;
    assign bus.tx_valid     = r_tx_valid;
    assign bus.tx_sof       = r_tx_sof;
    assign bus.tx_eof       = r_tx_eof;
    assign bus.busy         = r_busy;
    assign bus.pkt_done     = r_pkt_done;

endmodule

// File: tb/tb_pkt_reader.sv
module tb_pkt_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pkt_reader_if #(.ADDR_W(8), .LEN_W(8)) bus ();

    pkt_reader #(.ADDR_W(8), .LEN_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed { logic [7:0] la; logic [7:0] sz; } desc_t;
    typedef struct packed { logic sof; logic eof; logic [7:0] dat; } tb_byte_t;

    logic [7:0] mem [256];
    desc_t      dq [$];
    tb_byte_t   exp_b [$];
    logic [7:0] exp_a [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int fre_cyc = 0;
    int prev_size = 0;
    bit have_fre = 0;
    bit in_pkt = 0;
    bit pend_fre = 0;
    bit prev_hs_eof = 0;
    bit prev_valid = 0, prev_ready = 0, prev_sof = 0, prev_eof = 0;
    logic [7:0] prev_dat = 8'h00;
    int byte_idx = 0;
    int n_rd = 0, n_bytes = 0, n_done = 0, n_exp_done = 0;
    bit first_rd_pending = 0;
    logic [7:0] first_rd_addr = 8'h00;
    bit ready_rand = 0, hold_low = 0, stall_arm = 0;
    int stall_left = 0;

    // Packet RAM: one-cycle read latency; data is scrambled on cycles without a read.
    always @(posedge clk) begin
        if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
        else               bus.ram_rd_data <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty = (dq.size() == 0);
        if (dq.size() != 0) begin
            bus.fifo_last_addr = dq[0].la;
            bus.fifo_data_size = dq[0].sz;
        end else begin
            bus.fifo_last_addr = 8'($urandom);
            bus.fifo_data_size = 8'($urandom);
        end
    endtask

    task automatic push_desc(input logic [7:0] la, input logic [7:0] sz);
        desc_t d;
        d.la = la;
        d.sz = sz;
        dq.push_back(d);
        drive_fifo();
    endtask

    function automatic logic [7:0] outs_or();
        return {7'd0, bus.fifo_read_en | bus.ram_rd_en | bus.tx_valid | bus.tx_sof |
                bus.tx_eof | bus.busy | bus.pkt_done | (|bus.tx_data)};
    endfunction

    // One clock cycle: choose tx_ready, then check everything the DUT shows in this cycle.
    task automatic tick();
        desc_t    d;
        tb_byte_t e;
        logic [7:0] a;
        bit hs, exp_busy;
        // What the DUT samples at the coming edge is what is driven now.
        pend_fre = rst_n && !bus.busy && (dq.size() != 0);
        @(negedge clk);
        cyc++;

        if (stall_arm && bus.tx_valid && byte_idx == 1) begin
            stall_left = 10;
            stall_arm  = 0;
        end
        if (hold_low || stall_left > 0) bus.tx_ready = 1'b0;
        else if (ready_rand)            bus.tx_ready = ($urandom_range(0, 3) != 0);
        else                            bus.tx_ready = 1'b1;
        if (stall_left > 0) stall_left--;

        exp_busy = bus.fifo_read_en || in_pkt;
        chk("busy", bus.busy, exp_busy);
        chk("fre_timing", bus.fifo_read_en, pend_fre);
        chk("pkt_done", bus.pkt_done, prev_hs_eof);
        if (bus.pkt_done) n_done++;

        d = '0;
        if (bus.fifo_read_en) begin
            if (dq.size() == 0) begin
                chk("fre_on_empty", 1, 0);
            end else begin
                d = dq.pop_front();
                for (int i = 0; i < int'(d.sz); i++) begin
                    a = d.la - d.sz + 8'd1 + 8'(i);
                    exp_a.push_back(a);
                    e.dat = mem[a];
                    e.sof = (i == 0);
                    e.eof = (i == int'(d.sz) - 1);
                    exp_b.push_back(e);
                end
                if (d.sz != 0) n_exp_done++;
            end
            if (have_fre && prev_size != 0) chk("fre_gap", ((cyc - fre_cyc) >= 4), 1);
            fre_cyc = cyc;
            have_fre = 1;
            prev_size = int'(d.sz);
            first_rd_pending = 1;
            drive_fifo();
        end

        if (bus.ram_rd_en) begin
            n_rd++;
            chk("rd_while_valid", bus.tx_valid, 0);
            if (first_rd_pending) begin
                first_rd_addr = bus.ram_rd_addr;
                first_rd_pending = 0;
            end
            if (exp_a.size() == 0) chk("rd_extra", 1, 0);
            else                   chk("rd_addr", bus.ram_rd_addr, exp_a.pop_front());
        end

        if (prev_valid && !prev_ready) begin
            chk("hold_valid", bus.tx_valid, 1);
            chk("hold_byte", {bus.tx_sof, bus.tx_eof, bus.tx_data}, {prev_sof, prev_eof, prev_dat});
        end

        if (bus.tx_valid && !prev_valid && bus.tx_sof) chk("first_lat", cyc - fre_cyc, 3);

        hs = bus.tx_valid && bus.tx_ready;
        if (hs) begin
            n_bytes++;
            if (exp_b.size() == 0) chk("tx_extra", 1, 0);
            else chk("tx_byte", {bus.tx_sof, bus.tx_eof, bus.tx_data}, exp_b.pop_front());
            byte_idx = bus.tx_eof ? 0 : byte_idx + 1;
        end

        prev_hs_eof = hs && bus.tx_eof;
        prev_valid  = bus.tx_valid;
        prev_ready  = bus.tx_ready;
        prev_sof    = bus.tx_sof;
        prev_eof    = bus.tx_eof;
        prev_dat    = bus.tx_data;
        if (bus.fifo_read_en) in_pkt = (d.sz != 0);
        if (hs && bus.tx_eof) in_pkt = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((dq.size() != 0 || in_pkt || exp_b.size() != 0 || bus.busy || prev_hs_eof) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("timeout", 0, 1);
    endtask

    task automatic clear_model();
        exp_b.delete();
        exp_a.delete();
        if (in_pkt) n_exp_done--;
        in_pkt = 0;
        prev_hs_eof = 0;
        prev_valid = 0;
        prev_ready = 0;
        byte_idx = 0;
        stall_left = 0;
        have_fre = 0;
        first_rd_pending = 0;
    endtask

    initial begin
        int base, n;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        bus.tx_ready = 1'b0;
        drive_fifo();

        // Reset state
        #1;
        chk("reset_outs", outs_or(), 0);
        repeat (3) tick();
        chk("reset_outs_held", outs_or(), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_after_reset", outs_or(), 0);

        // Single packet
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 8'hA0 + 8'(i);
        base = n_done;
        push_desc(8'h13, 8'd4);
        wait_done(200);
        chk("single_start", first_rd_addr, 8'h10);
        chk("single_done", n_done - base, 1);

        // Wrap-around
        push_desc(8'h01, 8'd4);
        wait_done(200);
        chk("wrap_start", first_rd_addr, 8'hFE);

        // Zero size
        base = n_rd;
        n = n_done;
        push_desc(8'h55, 8'd0);
        wait_done(50);
        chk("zero_reads", n_rd - base, 0);
        chk("zero_done", n_done - n, 0);

        // Backpressure on byte 2
        base = n_rd;
        stall_arm = 1;
        push_desc(8'h80, 8'd4);
        wait_done(300);
        chk("bp_reads", n_rd - base, 4);
        chk("bp_stalled", stall_arm, 0);

        // Back-to-back single-byte packets
        n = n_done;
        push_desc(8'h20, 8'd1);
        push_desc(8'h40, 8'd1);
        wait_done(200);
        chk("b2b_done", n_done - n, 2);

        // Maximum size
        push_desc(8'h10, 8'd255);
        wait_done(2000);

        // Reset while a byte is held in SEND
        n = n_done;
        hold_low = 1;
        push_desc(8'h33, 8'd4);
        base = 0;
        while (!bus.tx_valid && base < 50) begin
            tick();
            base++;
        end
        if (base >= 50) chk("rst_wait_valid", 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", outs_or(), 0);
        clear_model();
        hold_low = 0;
        push_desc(8'h61, 8'd3);
        repeat (3) tick();
        chk("rst_no_done", n_done - n, 0);
        rst_n = 1'b1;
        wait_done(200);
        chk("rst_resume_done", n_done - n, 1);
        chk("rst_resume_start", first_rd_addr, 8'h5F);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        ready_rand = 1;
        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                base = $urandom_range(0, 19);
                push_desc(8'($urandom),
                          (base == 0) ? 8'd0 : (base == 1) ? 8'd255 : 8'($urandom_range(1, 10)));
            end
            repeat ($urandom_range(0, 20)) tick();
        end
        wait_done(20000);

        chk("left_bytes", exp_b.size(), 0);
        chk("left_addrs", exp_a.size(), 0);
        chk("done_total", n_done, n_exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
